// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_arbiter (with comp_add, fp_add_core)
// Function : Round-robin sharing of one combinational FP adder among NREQ
//            requesters; optional grant counters under FPU_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================

module fp_add_core #(
    parameter int EW = 8,
    parameter int FW = 23
) (
    input  logic [EW+FW:0] a,
    input  logic [EW+FW:0] b,
    output logic [EW+FW:0] sum
);
    localparam int M = FW + 1;
    localparam int W = FW + 5;
    localparam logic [EW-1:0] EALL = '1;

    logic          sx, sy, sub, rup, nan;
    logic [EW-1:0] ex, ey;
    logic [FW-1:0] fx, fy;
    logic [W-1:0]  mx, my, my_sh, s;
    logic [M:0]    man;
    int            e, d, lz, sh;

    always_comb begin
        sh = 0;
        if (b[EW+FW-1:0] > a[EW+FW-1:0]) begin
            sx = b[EW+FW]; ex = b[EW+FW-1:FW]; fx = b[FW-1:0];
            sy = a[EW+FW]; ey = a[EW+FW-1:FW]; fy = a[FW-1:0];
        end else begin
            sx = a[EW+FW]; ex = a[EW+FW-1:FW]; fx = a[FW-1:0];
            sy = b[EW+FW]; ey = b[EW+FW-1:FW]; fy = b[FW-1:0];
        end
        sub = sx ^ sy;
        mx  = {1'b0, ex != '0, fx, 3'b000};
        my  = {1'b0, ey != '0, fy, 3'b000};
        e   = (ex == '0) ? 1 : int'(ex);
        d   = e - ((ey == '0) ? 1 : int'(ey));
        // Bit 0 collects everything shifted out below the round bit
        if (d >= W) begin
            my_sh = {{(W-1){1'b0}}, |my};
        end else begin
            my_sh    = my >> d;
            my_sh[0] = my_sh[0] | (|(my & ~({W{1'b1}} << d)));
        end
        s  = sub ? (mx - my_sh) : (mx + my_sh);
        lz = W - 1;
        for (int i = 0; i < W - 1; i++) begin
            if (s[i]) lz = W - 2 - i;
        end
        if (s[W-1]) begin
            s = {1'b0, s[W-1:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            // Stop at the minimum exponent so tiny results become subnormal
            sh = (lz < e - 1) ? lz : e - 1;
            s  = s << sh;
            e  = e - sh;
        end
        rup = s[2] & (s[1] | s[0] | s[3]);
        man = {1'b0, s[W-2:3]} + {{M{1'b0}}, rup};
        if (man[M]) begin
            man = man >> 1;
            e   = e + 1;
        end
        nan = (ex == EALL && fx != '0) || (ey == EALL && fy != '0) ||
              (ex == EALL && ey == EALL && sub);
        if (nan)
            sum = {1'b0, EALL, 1'b1, {(FW-1){1'b0}}};
        else if (ex == EALL)
            sum = {sx, EALL, {FW{1'b0}}};
        else if (s == '0)
            sum = {sx & ~sub, {(EW+FW){1'b0}}};
        else if (e >= int'(EALL))
            sum = {sx, EALL, {FW{1'b0}}};
        else
            sum = {sx, man[M-1] ? EW'(e) : {EW{1'b0}}, man[FW-1:0]};
    end
endmodule

module comp_add #(
    parameter int DOUBLE = 0
) (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    generate
        if (DOUBLE != 0) begin : g_dp
            fp_add_core #(.EW(11), .FW(52)) u_core (.a(a), .b(b), .sum(sum));
        end else begin : g_sp
            logic [31:0] sum32;
            logic        unused_hi;
            assign unused_hi = ^{a[63:32], b[63:32]};
            fp_add_core #(.EW(8), .FW(23)) u_core (.a(a[31:0]), .b(b[31:0]), .sum(sum32));
            assign sum = {32'b0, sum32};
        end
    endgenerate
endmodule

module fpu_add_arbiter #(
    parameter  int DOUBLE = 0,
    parameter  int NREQ   = 4,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [63:0]        rsp_data,
    output logic [IDW-1:0]     rsp_id,
    input  logic               rsp_ready,
    output logic               busy
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);
    localparam logic [63:0] OP_MASK = (DOUBLE != 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                    : 64'h0000_0000_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state, state_next;
    logic [IDW-1:0]  rr_ptr, op_id, grant_idx;
    logic [NREQ-1:0] grant;
    logic            found;
    logic [63:0]     op_a, op_b, add_sum;

    comp_add #(.DOUBLE(DOUBLE)) u_add (.a(op_a), .b(op_b), .sum(add_sum));

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found                                 = 1'b1;
                grant[(int'(rr_ptr) + k) % NREQ]      = 1'b1;
                grant_idx                             = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = rst ? '0 : grant;
                if (found) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a  <= req_a[64*int'(grant_idx) +: 64] & OP_MASK;
                    op_b  <= req_b[64*int'(grant_idx) +: 64] & OP_MASK;
                    op_id <= grant_idx;
                end
                EXEC: begin
                    rsp_data  <= add_sum;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr_ptr    <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_ARB_STATS_EN
    logic [15:0] cnt [NREQ];
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt[i] <= '0;
                else if (req_ready[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
            end
            assign grant_cnt[16*i +: 16] = cnt[i];
        end
    endgenerate
`endif
endmodule

`default_nettype wire
